// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: op codes, register map and state encodings shared by the performance-counter master.
package perf_counter_pkg;

    typedef enum logic [1:0] {OP_RESET_ALL, OP_START, OP_STOP, OP_READ} op_e;
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_RESP} state_e;
    typedef enum logic [2:0] {RD_HI1, RD_LO, RD_HI2, RD_LO2, RD_EV} rd_step_e;
    typedef enum logic [1:0] {X_IDLE, X_REQ, X_WAIT} xfer_state_e;

    localparam int OFF_STOP    = 0;
    localparam int OFF_TIME_LO = 0;
    localparam int OFF_GO      = 1;
    localparam int OFF_TIME_HI = 1;
    localparam int OFF_EVENTS  = 2;
    localparam int SEC_STRIDE  = 4;

    function automatic int reg_addr(input logic [1:0] sec, input int off);
        return int'(sec) * SEC_STRIDE + off;
    endfunction

    function automatic int step_off(input rd_step_e s);
        return (s == RD_LO || s == RD_LO2) ? OFF_TIME_LO : (s == RD_EV) ? OFF_EVENTS : OFF_TIME_HI;
    endfunction

endpackage

// File: rtl/perf_counter_master_if.sv
// perf_counter_master_if: Avalon-MM master/slave signal bundle between the master and the counter slave.
interface perf_counter_master_if #(parameter int ADDR_W = 4);

    logic [ADDR_W-1:0] av_address;
    logic              av_write;
    logic              av_read;
    logic              av_begintransfer;
    logic [31:0]       av_writedata;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;

    modport master (
        output av_address, av_write, av_read, av_begintransfer, av_writedata,
        input  av_readdata, av_waitrequest
    );

    modport slave (
        input  av_address, av_write, av_read, av_begintransfer, av_writedata,
        output av_readdata, av_waitrequest
    );

endinterface

// File: rtl/avmm_single_xfer.sv
// avmm_single_xfer: issues one Avalon-MM read or write and signals completion with the returned data.
module avmm_single_xfer
    import perf_counter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    output logic                  granted,
    output logic                  done,
    output logic [31:0]           rdata,
    perf_counter_master_if.master av
);

    xfer_state_e       st;
    logic              first;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [7:0]        lat_cnt;
    logic              last;

    assign last = lat_cnt == 8'(READ_LATENCY - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= X_IDLE;
            first   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_cnt <= '0;
        end else begin
            first <= start;
            if (start) begin
                st      <= X_REQ;
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end else if (granted) begin
                st      <= wr_q ? X_IDLE : X_WAIT;
                lat_cnt <= '0;
            end else if (st == X_WAIT) begin
                st      <= last ? X_IDLE : X_WAIT;
                lat_cnt <= lat_cnt + 8'd1;
            end
        end
    end

    // Bus outputs are gated by the request state so address/data read as 0 when idle.
    always_comb begin
        granted             = st == X_REQ && !av.av_waitrequest;
        done                = (granted && wr_q) || (st == X_WAIT && last);
        rdata               = av.av_readdata;
        av.av_write         = st == X_REQ && wr_q;
        av.av_read          = st == X_REQ && !wr_q;
        av.av_begintransfer = st == X_REQ && first;
        av.av_address       = st == X_REQ ? addr_q : '0;
        av.av_writedata     = (st == X_REQ && wr_q) ? wdata_q : '0;
    end

endmodule

// File: rtl/perf_counter_master.sv
// perf_counter_master: sequences start/stop/reset writes and coherent 64-bit reads of the performance-counter slave.
module perf_counter_master
    import perf_counter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [1:0]            cmd_section,
    output logic                  rsp_valid,
    output logic [63:0]           rsp_time,
    output logic [31:0]           rsp_events,
    output logic                  done,
    perf_counter_master_if.master av
);

    state_e            state, state_nx;
    op_e               op_q, op_in;
    logic [1:0]        sec_q;
    rd_step_e          step_q, step_nx;
    logic [31:0]       hi_q, lo_q;
    logic              accept;
    logic              x_start, x_wr, x_granted, x_done;
    logic [ADDR_W-1:0] x_addr;
    logic [31:0]       x_wdata, x_rdata;

    assign op_in  = op_e'(cmd_op);
    assign accept = cmd_valid && cmd_ready;

    avmm_single_xfer #(.READ_LATENCY(READ_LATENCY), .ADDR_W(ADDR_W)) u_xfer (
        .clk     (clk),
        .reset   (reset),
        .start   (x_start),
        .wr      (x_wr),
        .addr    (x_addr),
        .wdata   (x_wdata),
        .granted (x_granted),
        .done    (x_done),
        .rdata   (x_rdata),
        .av      (av)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (accept)    state_nx = op_in == OP_READ ? S_RD_REQ : S_WR;
            S_WR:      if (x_done)    state_nx = S_RESP;
            S_RD_REQ:  if (x_granted) state_nx = S_RD_WAIT;
            S_RD_WAIT: if (x_done)    state_nx = step_q == RD_EV ? S_RESP : S_RD_REQ;
            default:                  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = state == S_IDLE;
        done      = state == S_RESP;
        rsp_valid = state == S_RESP && op_q == OP_READ;
    end

    // A changed high word between the two high reads means lo wrapped; re-read lo once.
    always_comb begin
        step_nx = step_q == RD_HI1 ? RD_LO :
                  step_q == RD_LO  ? RD_HI2 :
                  step_q == RD_HI2 ? (x_rdata != hi_q ? RD_LO2 : RD_EV) : RD_EV;
        x_start = accept || (state == S_RD_WAIT && x_done && step_q != RD_EV);
        x_wr    = state == S_IDLE && op_in != OP_READ;
        x_wdata = 32'(op_in == OP_RESET_ALL);
        x_addr  = state != S_IDLE        ? ADDR_W'(reg_addr(sec_q, step_off(step_nx))) :
                  op_in == OP_RESET_ALL  ? '0 :
                  ADDR_W'(reg_addr(cmd_section, op_in == OP_START ? OFF_GO :
                                                op_in == OP_STOP  ? OFF_STOP : OFF_TIME_HI));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_RESET_ALL;
            sec_q      <= '0;
            step_q     <= RD_HI1;
            hi_q       <= '0;
            lo_q       <= '0;
            rsp_time   <= '0;
            rsp_events <= '0;
        end else if (accept) begin
            op_q   <= op_in;
            sec_q  <= cmd_section;
            step_q <= RD_HI1;
        end else if (state == S_RD_WAIT && x_done) begin
            step_q <= step_nx;
            if (step_q == RD_HI1 || step_q == RD_HI2) hi_q <= x_rdata;
            if (step_q == RD_LO || step_q == RD_LO2)  lo_q <= x_rdata;
            if (step_q == RD_EV) begin
                rsp_time   <= {hi_q, lo_q};
                rsp_events <= x_rdata;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_master.sv
// tb_perf_counter_master: directed checks of perf_counter_master against a behavioural counter slave.
module tb_perf_counter_master;
    import perf_counter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [1:0]  cmd_section = '0;
    logic        rsp_valid;
    logic [63:0] rsp_time;
    logic [31:0] rsp_events;
    logic        done;
    int          n_tests = 0;
    int          n_fail = 0;

    perf_counter_master_if #(.ADDR_W(4)) bus();

    perf_counter_master #(.READ_LATENCY(1), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_section (cmd_section),
        .rsp_valid   (rsp_valid),
        .rsp_time    (rsp_time),
        .rsp_events  (rsp_events),
        .done        (done),
        .av          (bus)
    );

    always #5 clk = ~clk;

    // Counter slave: time counts every clock while running, go bumps the event count.
    logic [63:0] t [4]      = '{default: '0};
    logic [31:0] ev [4]     = '{default: '0};
    logic        run [4]    = '{default: 1'b0};
    int          rd_cnt [16] = '{default: 0};
    logic [31:0] rd = '0;
    logic        preset_en = 1'b0;
    logic [1:0]  preset_sec = '0;
    logic [63:0] preset_val = '0;
    logic [3:0]  stall_addr = '0;
    int          stall_req = 0;
    int          stall_used = 0;
    logic [3:0]  wlog [$];
    logic        overlap = 1'b0;
    logic [1:0]  s;

    assign s = bus.av_address[3:2];
    assign bus.av_waitrequest = bus.av_read && bus.av_address == stall_addr && stall_used < stall_req;
    assign bus.av_readdata = rd;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (run[i]) t[i] <= t[i] + 64'd1;
        if (preset_en) begin
            t[preset_sec]   <= preset_val;
            run[preset_sec] <= 1'b1;
        end
        if (bus.av_waitrequest) stall_used <= stall_used + 1;
        if (bus.av_read && bus.av_write) overlap <= 1'b1;
        if (bus.av_read && !bus.av_waitrequest) begin
            rd_cnt[bus.av_address] <= rd_cnt[bus.av_address] + 1;
            rd <= bus.av_address[1:0] == 2'd0 ? t[s][31:0] :
                  bus.av_address[1:0] == 2'd1 ? t[s][63:32] : ev[s];
        end
        if (bus.av_write && !bus.av_waitrequest) begin
            wlog.push_back(bus.av_address);
            if (bus.av_address == 4'd0 && bus.av_writedata == 32'd1) begin
                for (int i = 0; i < 4; i++) begin
                    t[i]   <= '0;
                    ev[i]  <= '0;
                    run[i] <= 1'b0;
                end
            end else if (bus.av_address[1:0] == 2'd1) begin
                run[s] <= 1'b1;
                ev[s]  <= ev[s] + 32'd1;
            end else if (bus.av_address[1:0] == 2'd0) begin
                run[s] <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] sec);
        int n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_section = sec;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, base, n_lo, n_bt, lo4;
        logic r1, r2, r3, seen;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_av_write", bus.av_write, 0);
        check("rst_av_read", bus.av_read, 0);
        check("rst_av_begin", bus.av_begintransfer, 0);
        check("rst_av_address", bus.av_address, 0);
        check("rst_av_writedata", bus.av_writedata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done", done, 0);
        check("rst_rsp_time", rsp_time, 0);
        check("rst_rsp_events", rsp_events, 0);
        reset = 1'b0;
        @(negedge clk);

        // RESET_ALL: single write to address 0 with data 1
        base = wlog.size();
        send(OP_RESET_ALL, 2'd0);
        check("ra_av_write", bus.av_write, 1);
        check("ra_av_read", bus.av_read, 0);
        check("ra_av_address", bus.av_address, 0);
        check("ra_av_writedata", bus.av_writedata, 1);
        check("ra_av_begin", bus.av_begintransfer, 1);
        check("ra_ready_c1", cmd_ready, 0);
        wait_done(cyc);
        check("ra_latency", cyc, 2);
        check("ra_ready_c2", cmd_ready, 0);
        check("ra_av_write_c2", bus.av_write, 0);
        @(negedge clk);
        check("ra_ready_c3", cmd_ready, 1);
        check("ra_done_c3", done, 0);
        check("ra_wcount", wlog.size() - base, 1);

        // START section 2, STOP 100 cycles later, then READ it back
        base = wlog.size();
        send(OP_START, 2'd2);
        wait_done(cyc);
        repeat (98) @(negedge clk);
        send(OP_STOP, 2'd2);
        wait_done(cyc);
        check("ss_wcount", wlog.size() - base, 2);
        check("ss_addr_go", wlog[base], 9);
        check("ss_addr_stop", wlog[base+1], 8);
        send(OP_READ, 2'd2);
        wait_done(cyc);
        check("rd2_rsp_valid", rsp_valid, 1);
        check("rd2_time_range", rsp_time >= 64'd98 && rsp_time <= 64'd102, 1);
        check("rd2_time_model", rsp_time, t[2]);
        check("rd2_events", rsp_events, 1);
        @(negedge clk);
        check("rd2_valid_pulse", rsp_valid, 0);
        check("rd2_time_hold", rsp_time, 100);

        // READ section 1 while time crosses the 32-bit boundary
        lo4 = rd_cnt[4];
        preset_sec = 2'd1;
        preset_val = 64'h0000_0000_FFFF_FFFE;
        preset_en = 1'b1;
        send(OP_READ, 2'd1);
        preset_en = 1'b0;
        wait_done(cyc);
        check("wrap_rsp_valid", rsp_valid, 1);
        check("wrap_time_hi", rsp_time[63:32], 1);
        check("wrap_time_lo_small", rsp_time[31:0] < 32'h10, 1);
        check("wrap_lo_reread", rd_cnt[4] - lo4, 2);

        // waitrequest held for 5 cycles on the lo read of section 2
        stall_addr = 4'd8;
        stall_req = 5;
        send(OP_READ, 2'd2);
        n_lo = 0;
        n_bt = 0;
        cyc = 1;
        while (!done && cyc < 300) begin
            if (bus.av_read && bus.av_address == 4'd8) begin
                n_lo++;
                n_bt += int'(bus.av_begintransfer);
            end
            @(negedge clk);
            cyc++;
        end
        check("stall_done", done, 1);
        check("stall_lo_cycles", n_lo, 6);
        check("stall_begin_once", n_bt, 1);
        check("stall_time", rsp_time, 100);
        check("stall_events", rsp_events, 1);

        // cmd_valid held while a STOP is in progress
        cyc = 0;
        while (!cmd_ready && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        base = wlog.size();
        cmd_valid = 1'b1;
        cmd_op = OP_STOP;
        cmd_section = 2'd3;
        @(negedge clk);
        cmd_op = OP_START;
        r1 = cmd_ready;
        @(negedge clk);
        r2 = cmd_ready;
        @(negedge clk);
        r3 = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(cyc);
        check("busy_ready_pattern", {r3, r2, r1}, 3'b100);
        check("busy_wcount", wlog.size() - base, 2);
        check("busy_addr_stop", wlog[base], 12);
        check("busy_addr_go", wlog[base+1], 13);
        check("busy_latency", cyc, 2);

        // asynchronous reset while a read is waiting for data
        @(negedge clk);
        send(OP_READ, 2'd0);
        check("mid_av_read", bus.av_read, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_av_read_rst", bus.av_read, 0);
        check("mid_av_write_rst", bus.av_write, 0);
        check("mid_av_begin_rst", bus.av_begintransfer, 0);
        check("mid_av_address_rst", bus.av_address, 0);
        check("mid_cmd_ready_rst", cmd_ready, 1);
        check("mid_rsp_time_rst", rsp_time, 0);
        check("mid_rsp_events_rst", rsp_events, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | rsp_valid | done;
        end
        check("mid_no_rsp", seen, 0);
        check("mid_ready_after", cmd_ready, 1);
        check("no_rd_wr_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_master.md
Name: perf_counter_master

Overview:
- Avalon-MM initiator that drives the 4-section performance-counter control slave from hardware, so measurement needs no CPU bus traffic.
- Accepts one command at a time from local logic: reset all, start section, stop section, or read section.
- Issues the required write or read transfers and returns a coherent 64-bit time count and 32-bit event count for the read command.
- Sits beside the counter slave in the SoC fabric and connects master-to-slave, either directly or through the interconnect.

Parameters:
- READ_LATENCY, 1: cycles from an accepted read to valid readdata (the counter slave registers readdata).
- ADDR_W, 4: word address width of the slave.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and accepts a command.
- cmd_op  in  2  0=RESET_ALL, 1=START, 2=STOP, 3=READ.
- cmd_section  in  2  section index 0..3.
- rsp_valid  out  1  one-cycle pulse; a READ result is valid.
- rsp_time  out  64  time counter of the section.
- rsp_events  out  32  event counter of the section.
- done  out  1  one-cycle pulse when any command completes.
- av_address  out  ADDR_W  word address.
- av_write  out  1  write request.
- av_read  out  1  read request.
- av_begintransfer  out  1  high only in the first cycle of each transfer.
- av_writedata  out  32  write data.
- av_readdata  in  32  read data.
- av_waitrequest  in  1  slave stall; tie to 0 for a direct connection.

Behaviour:
- Reset values:
  - cmd_ready=1.
  - All av_* outputs 0.
  - rsp_valid=0, done=0, rsp_time=0, rsp_events=0.
  - State=IDLE.
- Address map (base = section*4):
  - base+0: stop (write) / time low (read).
  - base+1: go (write) / time high (read).
  - base+2: events (read).
- States:
  - IDLE, WR, RD_REQ, RD_WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - A command is accepted when cmd_valid & cmd_ready; op and section are latched.
  - cmd_ready drops the next cycle.
- WR (RESET_ALL, START, STOP):
  - RESET_ALL: address 0, writedata 1.
  - START: address base+1, writedata 0.
  - STOP: address base+0, writedata 0.
  - av_write stays high until the first cycle with av_waitrequest=0.
  - av_begintransfer is high only in the first cycle of the transfer.
  - Then done pulses and the block returns to IDLE.
  - Latency is 2 cycles from acceptance to done when there is no stall.
- Read sequence (READ):
  - Reads in order: hi1 (base+1), lo (base+0), hi2 (base+1), ev (base+2).
  - If hi1 != hi2, lo is re-read after hi2, and time = {hi2, lo_reread}.
  - Otherwise time = {hi1, lo}.
  - At most one retry.
- RD_REQ / RD_WAIT:
  - RD_REQ holds av_read (begintransfer on its first cycle) until waitrequest=0.
  - RD_WAIT counts READ_LATENCY cycles, then captures av_readdata.
  - Only one read is outstanding at a time.
- RESP:
  - rsp_time and rsp_events are updated and rsp_valid and done pulse together for one cycle, then IDLE.
  - rsp_* hold their values until the next READ completes.
- av_read and av_write are never high together; av_address and av_writedata are stable while a request is held.
- cmd_valid during a busy state is ignored; the requester must hold it until cmd_ready.
- An invalid section is impossible (2-bit field). Any op code decodes as one of the four ops.
- Reset mid-transfer: all outputs return to their reset values immediately and any partial read result is discarded.
- No timeout: a permanent waitrequest stalls the block indefinitely.

Decomposition:
- Shared package perf_counter_pkg:
  - Op encodings.
  - Per-section register offsets (STOP/TIME_LO=0, GO/TIME_HI=1, EVENTS=2).
  - Section stride of 4.
  - State enum.
- One natural sub-module, avmm_single_xfer:
  - Issues one read or write with begintransfer / waitrequest / fixed read-latency handling.
  - Returns a done pulse and the captured data.
  - The top-level FSM sequences it.

Test Plan:
- RESET_ALL, no stall -> one write cycle with address=0, writedata=1, begintransfer=1; done 2 cycles after acceptance; cmd_ready low for exactly 2 cycles.
- START section 2, then STOP 100 cycles later, against a counter slave model -> writes to addresses 9 then 8; READ section 2 returns rsp_time ≈ 100 ±2 and rsp_events=1.
- READ section 1 with time counter preset to 0x0000_0000_FFFF_FFFE while running -> hi1≠hi2 triggers a lo re-read; rsp_time=0x0000_0001_xxxx_xxxx with lo < 0x10.
- av_waitrequest held high for 5 cycles on the lo read -> av_read and av_address stable throughout, begintransfer high only in the first cycle; result correct.
- reset asserted during RD_WAIT -> all av_* outputs 0 in the same cycle; cmd_ready=1 after release; no rsp_valid.
- cmd_valid held high while busy with a STOP -> second command accepted only in the cycle cmd_ready=1; no overlapping transfers.
